// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or
// signed (truncating) operands, with divide-by-zero and overflow flags.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_i            request, sampled only while busy_o = 0
//   signed_mode_i      1 = two's-complement operands (needs SIGNED_EN)
//   dividend_i         N-bit dividend, sampled with start_i
//   divisor_i          N-bit divisor, sampled with start_i
//   busy_o             high while a division is in progress
//   done_o             one-cycle completion pulse
//   quotient_o         registered quotient, held until next completion
//   remainder_o        registered remainder, held until next completion
//   div_by_zero_o      divisor was zero (held with results)
//   overflow_o         signed -2^(N-1) / -1 (held with results)
module seq_restoring_divider #(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         signed_mode_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_by_zero_o,
    output logic         overflow_o
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t         state_q;
    logic [N-1:0]   p_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [CW-1:0]  cnt_q;
    logic           sgn_q_q;
    logic           sgn_r_q;
    logic           dz_q;
    logic           ov_q;

    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   quo_q;
    logic [N-1:0]   rem_q;
    logic           dzo_q;
    logic           ovo_q;

    logic           sm;
    logic           neg_a;
    logic           neg_b;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic           zero_b;
    logic           ovf;

    logic [N:0]     sh_p;
    logic [N:0]     trial;
    logic [N-1:0]   quo_d;
    logic [N-1:0]   rem_d;

    assign sm     = SIGNED_EN & signed_mode_i;
    assign neg_a  = sm & dividend_i[N-1];
    assign neg_b  = sm & divisor_i[N-1];
    // Negating -2^(N-1) wraps to itself, which is the correct
    // unsigned magnitude 2^(N-1).
    assign mag_a  = neg_a ? -dividend_i : dividend_i;
    assign mag_b  = neg_b ? -divisor_i : divisor_i;
    assign zero_b = (divisor_i == '0);
    assign ovf    = sm
                  & (dividend_i == {1'b1, {(N-1){1'b0}}})
                  & (&divisor_i);

    // The settled partial remainder is always below the divisor, so it
    // fits in N bits; only the shifted value needs the extra bit.
    assign sh_p  = {p_q, a_q[N-1]};
    assign trial = sh_p - {1'b0, b_q};

    // On divide-by-zero a_q carries the raw dividend for the remainder.
    always_comb begin
        quo_d = sgn_q_q ? -a_q : a_q;
        rem_d = sgn_r_q ? -p_q : p_q;
        if (dz_q) begin
            quo_d = '1;
            rem_d = a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= zero_b ? dividend_i : mag_a;
                        b_q     <= mag_b;
                        p_q     <= '0;
                        cnt_q   <= '0;
                        sgn_q_q <= neg_a ^ neg_b;
                        sgn_r_q <= neg_a;
                        dz_q    <= zero_b;
                        ov_q    <= ovf;
                        busy_q  <= 1'b1;
                        state_q <= zero_b ? FIX : CALC;
                    end
                end
                CALC: begin
                    // Negative trial restores the shifted remainder.
                    p_q   <= trial[N] ? sh_p[N-1:0] : trial[N-1:0];
                    a_q   <= {a_q[N-2:0], ~trial[N]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quo_q   <= quo_d;
                    rem_q   <= rem_d;
                    dzo_q   <= dz_q;
                    ovo_q   <= ov_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dzo_q;
    assign overflow_o    = ovo_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: N=8 main instance with
// random and directed vectors, plus N=4 and N=16 width checks.
module tb_seq_restoring_divider;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         sm = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, dz, ov;
    logic [N-1:0] q, r;

    logic        s4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, dz4, ov4;
    logic [3:0]  q4, r4;

    logic        s16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, dz16, ov16;
    logic [15:0] q16, r16;

    seq_restoring_divider #(.N(N), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .signed_mode_i(sm),
        .dividend_i(a), .divisor_i(b), .busy_o(busy), .done_o(done),
        .quotient_o(q), .remainder_o(r), .div_by_zero_o(dz),
        .overflow_o(ov)
    );

    seq_restoring_divider #(.N(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .start_i(s4), .signed_mode_i(1'b0),
        .dividend_i(a4), .divisor_i(b4), .busy_o(busy4),
        .done_o(done4), .quotient_o(q4), .remainder_o(r4),
        .div_by_zero_o(dz4), .overflow_o(ov4)
    );

    seq_restoring_divider #(.N(16), .SIGNED_EN(1'b1)) dut16 (
        .clk(clk), .rst(rst), .start_i(s16), .signed_mode_i(1'b0),
        .dividend_i(a16), .divisor_i(b16), .busy_o(busy16),
        .done_o(done16), .quotient_o(q16), .remainder_o(r16),
        .div_by_zero_o(dz16), .overflow_o(ov16)
    );

    int vec = 0;
    int err = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];

    // Reference: plain integer division (truncating) on sign-extended
    // values, with the two special cases handled explicitly.
    function automatic exp_t model(logic [N-1:0] x, logic [N-1:0] y,
                                   logic s);
        exp_t e;
        longint sx, sy;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.acc = 0;
        e.lat = N + 1;
        if (y == 0) begin
            e.q   = '1;
            e.r   = x;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            if (sx == -(longint'(1) << (N - 1)) && sy == -1) begin
                e.q  = N'(longint'(1) << (N - 1));
                e.r  = '0;
                e.ov = 1'b1;
            end else begin
                e.q = N'(sx / sy);
                e.r = N'(sx % sy);
            end
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            vec++;
            if (sb.size() == 0) begin
                err++;
                $display("FAIL spurious_done at cyc %0d q=%h r=%h",
                         cyc, q, r);
            end else begin
                e = sb.pop_front();
                if ({q, r, dz, ov} !== {e.q, e.r, e.dz, e.ov}
                    || cyc != e.acc + e.lat) begin
                    err++;
                    $display({"FAIL div got q=%h r=%h dz=%b ov=%b ",
                              "cyc=%0d want q=%h r=%h dz=%b ov=%b ",
                              "cyc=%0d"},
                             q, r, dz, ov, cyc,
                             e.q, e.r, e.dz, e.ov, e.acc + e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic s);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        sm    = s;
        e     = model(x, y, s);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        sm    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            vec++;
            err++;
            $display("FAIL timeout pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int bl;
        int nd;
        int k;
        int c0;
        exp_t e;
        logic [N-1:0] x, y;
        logic s;

        #12;
        vec++;
        if ({busy, done, q, r, dz, ov} !== '0) begin
            err++;
            $display("FAIL reset_state got %b want 0",
                     {busy, done, q, r, dz, ov});
        end
        @(negedge clk);
        rst = 1'b0;

        // 100 / 7 with busy length
        issue(8'd100, 8'd7, 1'b0);
        bl = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bl++;
            @(negedge clk);
        end
        vec++;
        if (bl != N + 1) begin
            err++;
            $display("FAIL busy_len got %0d want %0d", bl, N + 1);
        end
        wait_idle();

        issue(8'h9C, 8'd7, 1'b1);   wait_idle();
        issue(8'd100, 8'hF9, 1'b1); wait_idle();
        issue(8'h9C, 8'hF9, 1'b1);  wait_idle();
        issue(8'h80, 8'hFF, 1'b1);  wait_idle();
        issue(8'h80, 8'hFF, 1'b0);  wait_idle();
        issue(8'd55, 8'd0, 1'b0);   wait_idle();
        issue(8'd55, 8'd0, 1'b1);   wait_idle();
        issue(8'd100, 8'd7, 1'b1);  wait_idle();

        // Asynchronous reset in the middle of 200 / 3
        issue(8'd200, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({busy, done, q, r, dz, ov} !== '0) begin
            err++;
            $display("FAIL abort_reset got %b want 0",
                     {busy, done, q, r, dz, ov});
        end
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        vec++;
        if (nd != 0) begin
            err++;
            $display("FAIL abort_done got %0d want 0", nd);
        end
        issue(8'd200, 8'd3, 1'b0);
        wait_idle();

        // start held high; operands change while busy
        @(negedge clk);
        start = 1'b1;
        a     = 8'd250;
        b     = 8'd10;
        sm    = 1'b0;
        e     = model(8'd250, 8'd10, 1'b0);
        e.acc = cyc + 1;
        sb.push_back(e);
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            a  = N'($urandom);
            b  = N'($urandom);
            sm = 1'($urandom);
        end
        @(negedge clk);
        a     = N'($urandom);
        b     = N'($urandom_range(1, 255));
        sm    = 1'($urandom);
        e     = model(a, b, sm);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Random vectors with corner cases mixed in
        repeat (40) begin
            x = N'($urandom);
            y = N'($urandom);
            s = 1'($urandom);
            k = $urandom_range(0, 9);
            if (k == 0) y = '0;
            if (k == 1) begin
                x = 8'h80;
                y = 8'hFF;
            end
            if (k == 2) y = 8'd1;
            issue(x, y, s);
            wait_idle();
        end

        // N=4: 9 / 2
        @(negedge clk);
        s4 = 1'b1;
        a4 = 4'd9;
        b4 = 4'd2;
        c0 = cyc + 1;
        @(negedge clk);
        s4 = 1'b0;
        k = 0;
        while (!done4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        vec++;
        if (!done4 || q4 !== 4'd4 || r4 !== 4'd1 || cyc != c0 + 5) begin
            err++;
            $display("FAIL n4 got q=%0d r=%0d cyc=%0d want 4 1 %0d",
                     q4, r4, cyc, c0 + 5);
        end

        // N=16: 65535 / 255
        @(negedge clk);
        s16 = 1'b1;
        a16 = 16'd65535;
        b16 = 16'd255;
        c0  = cyc + 1;
        @(negedge clk);
        s16 = 1'b0;
        k = 0;
        while (!done16 && k < 60) begin
            @(negedge clk);
            k++;
        end
        vec++;
        if (!done16 || q16 !== 16'd257 || r16 !== 16'd0
            || cyc != c0 + 17) begin
            err++;
            $display("FAIL n16 got q=%0d r=%0d cyc=%0d want 257 0 %0d",
                     q16, r16, cyc, c0 + 17);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
